// File: rtl/data_mem_unit.sv
// data_mem_unit: load/store unit behind the ALU in the multi-cycle ARM core.
// Performs word and byte accesses on an internal single-port RAM. Byte stores
// use a read-modify-write through the MERGE state.
//
// Handshake: a request is accepted only on a rising edge where start=1 and the
// unit is idle (busy=0). All request fields are captured at that edge. done is
// a single-cycle pulse, and load_data/align_fault are valid while done=1.
// start seen while busy=1 is dropped and has no effect.
module data_mem_unit #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_byte,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        align_fault,
    output logic [1:0]  state_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_MERGE   = 2'd2;
    localparam logic [1:0] S_RESPOND = 2'd3;

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [1:0]            state_q, state_d;
    logic                  is_load_q, is_load_d;
    logic                  is_byte_q, is_byte_d;
    logic [ADDR_WIDTH+1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           merge_q, merge_d;
    logic [31:0]           load_data_q, load_data_d;
    logic                  align_fault_q, align_fault_d;

    logic [31:0]           mem_q [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            lane;
    logic                  misaligned;
    logic [31:0]           ram_rdata;
    logic [7:0]            lane_byte;
    logic [31:0]           merged_word;
    logic                  ram_we;
    logic [31:0]           ram_wdata;

    // Address bits above the RAM size are ignored, so accesses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

    assign word_idx   = addr_q[ADDR_WIDTH+1:2];
    assign lane       = addr_q[1:0];
    assign misaligned = !is_byte_q && (lane != 2'b00);
    assign ram_rdata  = mem_q[word_idx];
    assign lane_byte  = ram_rdata[{lane, 3'b000} +: 8];

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_RESPOND);
    assign load_data   = load_data_q;
    assign align_fault = align_fault_q;
    assign state_o     = state_q;

    // Insert the store byte into the word read during ACCESS (little-endian lanes).
    always_comb begin
        merged_word = merge_q;
        merged_word[{lane, 3'b000} +: 8] = wdata_q[7:0];
    end

    // Next-state, capture and RAM control for the four-state transfer sequence.
    always_comb begin
        state_d       = state_q;
        is_load_d     = is_load_q;
        is_byte_d     = is_byte_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        merge_d       = merge_q;
        load_data_d   = load_data_q;
        align_fault_d = align_fault_q;
        ram_we        = 1'b0;
        ram_wdata     = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_load_d     = is_load;
                    is_byte_d     = is_byte;
                    addr_d        = addr[ADDR_WIDTH+1:0];
                    wdata_d       = store_data;
                    align_fault_d = 1'b0;
                    state_d       = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (misaligned) begin
                    // No RAM access; load_data keeps its previous value.
                    align_fault_d = 1'b1;
                    state_d       = S_RESPOND;
                end else if (is_load_q) begin
                    load_data_d = is_byte_q ? {24'b0, lane_byte} : ram_rdata;
                    state_d     = S_RESPOND;
                end else if (!is_byte_q) begin
                    ram_we  = 1'b1;
                    state_d = S_RESPOND;
                end else begin
                    merge_d = ram_rdata;
                    state_d = S_MERGE;
                end
            end
            S_MERGE: begin
                ram_we    = 1'b1;
                ram_wdata = merged_word;
                state_d   = S_RESPOND;
            end
            default: begin
                align_fault_d = 1'b0;
                state_d       = S_IDLE;
            end
        endcase
    end

    // RAM write port; suppressed during reset so an in-flight write is dropped.
    always_ff @(posedge clk) begin
        if (ram_we && !nreset) begin
            mem_q[word_idx] <= ram_wdata;
        end
    end

    // Control and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (nreset) begin
            state_q       <= S_IDLE;
            is_load_q     <= 1'b0;
            is_byte_q     <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            merge_q       <= '0;
            load_data_q   <= '0;
            align_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            is_load_q     <= is_load_d;
            is_byte_q     <= is_byte_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            merge_q       <= merge_d;
            load_data_q   <= load_data_d;
            align_fault_q <= align_fault_d;
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// Testbench for data_mem_unit: directed scenarios plus random traffic against
// a word-array reference model, with a done-driven scoreboard monitor.
module tb_data_mem_unit;

    logic        clk = 1'b0;
    logic        nreset;
    logic        start;
    logic        is_load;
    logic        is_byte;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        align_fault;
    logic [1:0]  state_o;

    data_mem_unit #(.ADDR_WIDTH(8)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .start       (start),
        .is_load     (is_load),
        .is_byte     (is_byte),
        .addr        (addr),
        .store_data  (store_data),
        .busy        (busy),
        .done        (done),
        .load_data   (load_data),
        .align_fault (align_fault),
        .state_o     (state_o)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: RAM as a plain word array, plus the last load result.
    logic [31:0] mem_m [256];
    logic [31:0] ld_m;

    // Scoreboard entries: {done cycle, align_fault, load_data}.
    logic [64:0] exp_q [$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every done pulse is matched against the head of the queue.
    always @(negedge clk) begin
        logic [64:0] e;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", cyc, e[64:33]);
                check("align_fault", {31'b0, align_fault}, {31'b0, e[32]});
                check("load_data", load_data, e[31:0]);
            end
        end else if (exp_q.size() > 0 && cyc > int'(exp_q[0][64:33])) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_done: got no done expected at cycle %0d (now %0d)", e[64:33], cyc);
        end
    end

    // Driver: issue one request, update the model, then keep the bus noisy while busy.
    task automatic issue(input logic ld, input logic by, input logic [31:0] a,
                         input logic [31:0] d, input bit poke);
        int          lat;
        int          idx;
        int          ln;
        logic        fault;
        logic [31:0] c;
        idx   = int'(a[9:2]);
        ln    = int'(a[1:0]);
        fault = !by && (a[1:0] != 2'b00);
        lat   = 2;
        if (!fault) begin
            if (ld) begin
                ld_m = by ? ((mem_m[idx] >> (8 * ln)) & 32'hFF) : mem_m[idx];
            end else if (by) begin
                mem_m[idx][8*ln +: 8] = d[7:0];
                lat = 3;
            end else begin
                mem_m[idx] = d;
            end
        end
        c = cyc + lat;
        exp_q.push_back({c, fault, ld_m});
        start      = 1'b1;
        is_load    = ld;
        is_byte    = by;
        addr       = a;
        store_data = d;
        for (int i = 0; i < lat + 1; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) check("busy_high", {31'b0, busy}, 32'd1);
            if (poke && i < lat) begin
                start      = 1'b1;
                is_load    = 1'b0;
                is_byte    = 1'b0;
                addr       = 32'h50;
                store_data = $urandom;
            end else begin
                start      = 1'b0;
                is_load    = 1'($urandom_range(0, 1));
                is_byte    = 1'($urandom_range(0, 1));
                addr       = $urandom;
                store_data = $urandom;
            end
        end
        check("busy_low", {31'b0, busy}, 32'd0);
    endtask

    // Byte store interrupted by reset while in MERGE: RAM word must stay intact.
    task automatic reset_in_merge(input logic [31:0] a, input logic [31:0] d);
        start      = 1'b1;
        is_load    = 1'b0;
        is_byte    = 1'b1;
        addr       = a;
        store_data = d;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("merge_busy", {31'b0, busy}, 32'd1);
        nreset = 1'b1;
        @(posedge clk); #1;
        nreset = 1'b0;
        ld_m   = 32'h0;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_align_fault", {31'b0, align_fault}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        nreset     = 1'b1;
        start      = 1'b0;
        is_load    = 1'b0;
        is_byte    = 1'b0;
        addr       = '0;
        store_data = '0;
        ld_m       = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_load_data", load_data, 32'd0);
        check("reset_align_fault", {31'b0, align_fault}, 32'd0);
        nreset = 1'b0;
        @(posedge clk); #1;

        // Fill every word so the model knows the full RAM image.
        for (int i = 0; i < 256; i++) issue(1'b0, 1'b0, i * 4, $urandom, 1'b0);

        // Word store then load.
        issue(1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

        // Byte store merge.
        issue(1'b0, 1'b0, 32'h20, 32'h11223344, 1'b0);
        issue(1'b0, 1'b1, 32'h22, 32'h000000AA, 1'b0);
        issue(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

        // Byte load zero-extension on every lane.
        issue(1'b0, 1'b0, 32'h30, 32'h80FF7F01, 1'b0);
        for (int i = 0; i < 4; i++) issue(1'b1, 1'b1, 32'h30 + i, 32'h0, 1'b0);

        // Misaligned word store and load.
        issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b0, 1'b0, 32'h41, 32'h12345678, 1'b0);
        issue(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 32'h43, 32'h0, 1'b0);

        // start while busy is ignored; 0x50 keeps its contents.
        issue(1'b0, 1'b1, 32'h61, 32'h0000005A, 1'b1);
        issue(1'b1, 1'b0, 32'h50, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 32'h60, 32'h0, 1'b0);

        // Address wrap: 0x400 aliases word 0.
        issue(1'b0, 1'b0, 32'h400, 32'hCAFEF00D, 1'b0);
        issue(1'b1, 1'b0, 32'h000, 32'h0, 1'b0);

        // Reset during MERGE, then a fresh load of the same word.
        reset_in_merge(32'h72, 32'h000000EE);
        issue(1'b1, 1'b0, 32'h70, 32'h0, 1'b0);

        // Random traffic over the full address space.
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                  ($urandom_range(0, 3) == 0));
        end

        repeat (4) @(posedge clk);
        #1;
        check("pending_expect", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Load/store unit for the multi-cycle ARM core's `dataMemory` state. It sits directly downstream of the ALU: it consumes the ALU result as a byte address, plus the store data and transfer flags decoded from the single-data-transfer instruction. It performs the word or byte access on an internal synchronous-read RAM and hands load data to the writeback state. The control FSM pulses `start` and waits for `done`.

## Interface
Parameters:
- ADDR_WIDTH, 8: word-address bits; RAM depth is 2^ADDR_WIDTH 32-bit words.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- nreset  input  1  reset, synchronous, active-high.
- start  input  1  request strobe; sampled only in IDLE.
- is_load  input  1  1 = load (LDR/LDRB), 0 = store (STR/STRB).
- is_byte  input  1  1 = byte transfer, 0 = word transfer.
- addr  input  32  byte address (ALU result).
- store_data  input  32  Rd contents for stores; for byte stores only [7:0] is used.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- load_data  output  32  load result; byte loads are zero-extended.
- align_fault  output  1  valid with done; set for a misaligned word access.

## Operation
- FSM states: IDLE, ACCESS, MERGE, RESPOND.
- Request capture: in IDLE with start=1, latch is_load, is_byte, addr and store_data, then go to ACCESS. The latched values are used for the whole transaction. Input changes after capture are ignored.
- start while busy=1 is ignored. It is neither queued nor does it corrupt the transaction in flight.
- Word index: addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so accesses wrap modulo the RAM size.
- Byte lane: addr[1:0], little-endian. Lane 0 is bits [7:0]; lane 3 is bits [31:24].
- Misaligned word access (is_byte=0 and addr[1:0]≠00):
  - ACCESS performs no RAM read or write.
  - Next state is RESPOND with align_fault=1.
  - load_data is left unchanged.
- Word load: ACCESS issues the RAM read. RESPOND drives load_data with the RAM word.
- Byte load: ACCESS issues the RAM read. RESPOND drives load_data = {24'b0, selected byte}.
- Word store: the RAM word is written at the end of ACCESS. Next state is RESPOND.
- Byte store (read-modify-write):
  - ACCESS reads the word.
  - MERGE replaces the selected lane with store_data[7:0] and writes the merged word at the end of MERGE.
  - Next state is RESPOND.
- RESPOND: done=1 for exactly one cycle, then IDLE.
- align_fault is 0 on every non-faulting done.
- load_data holds its value until the next non-faulting load completes. Stores never change it.
- Reset values: busy=0, done=0, align_fault=0, load_data=0, state IDLE.
- RAM contents are not cleared by reset.
- Reset mid-operation: return to IDLE next cycle with no done pulse. A write not yet committed is discarded; a byte store reset during MERGE leaves the RAM word unmodified.

## Timing
- Cycle numbering: cycle 0 = the edge where start is sampled in IDLE.
- Word load, word store, byte load: ACCESS in cycle 1, done in cycle 2. Latency is 2 cycles.
- Byte store: ACCESS in cycle 1, MERGE in cycle 2, done in cycle 3. Latency is 3 cycles.
- Misaligned word access: done with align_fault in cycle 2.
- busy rises in cycle 1 and falls in the cycle after done.
- Back-to-back requests: the earliest next start is accepted in the cycle after RESPOND, i.e. when busy=0. Throughput is 1 access per 3 cycles (4 for byte stores).
- RAM read latency is 1 cycle: an address presented in ACCESS gives data in the next state.
- Read-after-write: a load issued after a store's done returns the new data. There is no forwarding requirement within a transaction.
- load_data and align_fault are registered outputs. They are stable in the done cycle.

## Test plan
- Word store then load: store 0xDEADBEEF at addr 0x10, then load 0x10. Required: done 2 cycles after each start, load_data=0xDEADBEEF, align_fault=0.
- Byte store merge: word 0x11223344 at 0x20, byte store 0xAA at 0x22, word load 0x20. Required: store done in cycle 3, load_data=0x11AA3344.
- Byte load zero-extension: word 0x80FF7F01 at 0x30. Byte loads at 0x30..0x33 return 0x01, 0x7F, 0xFF, 0x80 in the low byte, with upper 24 bits zero.
- Misaligned word access: word store 0x12345678 at 0x41. Required: done with align_fault=1 in cycle 2. A word load at 0x40 afterwards returns the old contents. A misaligned load leaves load_data unchanged.
- Busy and wrap: during a byte store, pulse start with a word store to 0x50. Required: the second request is ignored and 0x50 is unchanged. With ADDR_WIDTH=8, a store to 0x400 then a load from 0x000 returns the stored value.
- Reset mid byte store: assert nreset while in MERGE. Required: next cycle busy=0, done=0, load_data=0, target word unchanged. A fresh load starting in IDLE completes normally.
